uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of uart_top.
- Captures every byte uart_top reports via rx_valid/rx_data into a DEPTH-entry FIFO.
- Presents bytes to the consumer (loopback logic, LED/debug logic, host command parser) through a first-word-fall-through read port.
- Reports occupancy, almost-full and a sticky overflow flag so lost bytes are visible on the Arty7 board.

Parameters:
- DATA_W, 8, byte width; matches uart_top rx_data.
- DEPTH, 16, number of entries; must be a power of 2, minimum 4.
- ADDR_W, $clog2(DEPTH), pointer width; derived, do not override.
- AF_LEVEL, DEPTH-2, count at or above which almost_full asserts.

Ports:
- clk  in  1  system clock; single clock domain shared with uart_top.
- rst  in  1  synchronous reset, active-high.
- rx_valid  in  1  one-cycle strobe from uart_top: rx_data holds a new byte.
- rx_data  in  DATA_W  received byte; sampled only when rx_valid=1.
- rd_en  in  1  consumer pop request; honoured only when rd_valid=1.
- rd_data  out  DATA_W  head-of-FIFO byte; valid while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- count  out  ADDR_W+1  number of stored bytes, 0..DEPTH.
- full  out  1  count==DEPTH.
- almost_full  out  1  count>=AF_LEVEL.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (sampled at a clk edge with rst=1):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs: rd_valid=0, full=0, almost_full=0, rd_data=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored bytes. rx_valid in the reset cycle is ignored.
- Storage: register array mem[DEPTH]. Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. count is maintained separately, with no extra pointer bit.
- Push: at an edge with rx_valid=1 and (count<DEPTH or a pop occurs at the same edge):
  - mem[wr_ptr]<=rx_data, wr_ptr+1.
- Pop: at an edge with rd_en=1 and rd_valid=1: rd_ptr+1.
- rd_en while empty is a no-op; no flag is raised.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - both, or neither: count unchanged.
- FWFT read port:
  - rd_data = mem[rd_ptr] combinationally when count!=0, else 0.
  - rd_valid = (count!=0).
- Latency: a byte strobed at edge k is visible on rd_data/rd_valid immediately after edge k. Pop at edge j means the next byte, or rd_valid=0, is shown after edge j.
- Full with simultaneous push and pop: both are performed, count stays at DEPTH, no overflow.
- Full with push and no pop:
  - Byte is dropped; memory and pointers are unchanged.
  - overflow<=1 at that edge.
- overflow:
  - Set by a dropped byte; cleared by ovf_clr=1.
  - If both occur at the same edge, set wins.
  - Remains 1 until cleared or reset.
- Empty with simultaneous push and pop: the pop is ignored (rd_valid was 0). The push occurs, count becomes 1.
- full and almost_full are combinational decodes of count.
- Ordering: strict FIFO; no byte is reordered or duplicated.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W=8, shared with uart_top.
  - Default FIFO depth constant RX_FIFO_DEPTH=16.
- One sub-module is natural: fifo_ctrl.
  - Holds pointer/count logic, full/empty decode and the push/pop qualification.
  - Is reused later for the TX-side FIFO feeding uart_top tx_start/tx_data.
- Memory array and overflow flag stay in uart_rx_fifo.

Test Plan:
1. Reset, then strobe rx_valid with rx_data=0x55 for 1 cycle -> next cycle rd_valid=1, rd_data=0x55, count=1. Pulse rd_en -> rd_valid=0, count=0, rd_data=0.
2. Push 0x01..0x10 (16 bytes) with no pops -> full=1, count=16, almost_full asserted from count=14. Drain -> bytes 0x01..0x10 in order.
3. Full FIFO, push 0xAA with rd_en=0 -> overflow=1, count=16, drained data still 0x01..0x10. ovf_clr=1 -> overflow=0. Simultaneous ovf_clr and dropped push -> overflow stays 1.
4. Full FIFO, push 0x36 with rd_en=1 at the same edge -> count stays 16, overflow=0, 0x36 emerges last on drain.
5. Wrap-around: 40 interleaved push/pop cycles with an incrementing pattern, occupancy held between 1 and 3 -> output sequence matches input, no overflow.
6. Loopback: connect to uart_top with rx=tx, send 0x55 then 0x36 via tx_start -> FIFO holds 0x55, 0x36. Assert rst mid-stream -> count=0, rd_valid=0, overflow=0 on the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Constants and types shared by the UART core and its RX/TX FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Depth legality: a power of two, at least four entries.
    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Purpose  : Pointer/count bookkeeping and push/pop qualification for a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push_req,
    input  logic              i_pop_req,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic              o_drop,
    output logic [ADDR_W-1:0] o_wr_ptr,
    output logic [ADDR_W-1:0] o_rd_ptr,
    output logic [ADDR_W:0]   o_count,
    output logic              o_empty,
    output logic              o_full
);

    localparam logic [ADDR_W:0] c_full_count = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);

    // A pop on the same edge frees the slot a push needs when full.
    assign w_pop  = i_pop_req & ~w_empty;
    assign w_push = i_push_req & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wr_en  = w_push & ~rst;
    assign o_rd_en  = w_pop & ~rst;
    assign o_drop   = i_push_req & ~w_push & ~rst;
    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
    assign o_empty  = w_empty;
    assign o_full   = w_full;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : First-word-fall-through receive buffer behind uart_top.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_DATA_W,
    parameter int DEPTH    = RX_FIFO_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0] c_af_level = (ADDR_W + 1)'(AF_LEVEL);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_overflow;

    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_drop;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic [ADDR_W:0]   w_count;
    logic              w_empty;
    logic              w_full;

    generate
        if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
            // Unresolvable instance stops elaboration on an illegal depth.
            fifo_depth_must_be_pow2_min4 u_bad_depth ();
        end
    endgenerate

    fifo_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_push_req (rx_valid),
        .i_pop_req  (rd_en),
        .o_wr_en    (w_wr_en),
        .o_rd_en    (w_rd_en),
        .o_drop     (w_drop),
        .o_wr_ptr   (w_wr_ptr),
        .o_rd_ptr   (w_rd_ptr),
        .o_count    (w_count),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_ptr] <= rx_data;
        end
    end

    // Sticky loss indicator; a drop on the clearing edge keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign rd_data     = w_empty ? '0 : r_mem[w_rd_ptr];
    assign rd_valid    = ~w_empty;
    assign count       = w_count;
    assign full        = w_full;
    assign almost_full = (w_count >= c_af_level);
    assign overflow    = r_overflow;

    logic w_unused;
    assign w_unused = w_rd_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed scoreboard bench for uart_rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_depth = 16;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       ovf_clr;

    uart_rx_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors;
    int         miscompares;
    logic [7:0] sb_q[$];
    logic       m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs with the model, then apply inputs across one edge.
    task automatic cycle(input logic rv, input logic [7:0] d, input logic rd, input logic clr);
        int  occ;
        bit  pop;
        bit  push;
        occ = sb_q.size();
        check("rd_valid", 32'(rd_valid), 32'(occ != 0));
        check("count", 32'(count), 32'(occ));
        check("full", 32'(full), 32'(occ == c_depth));
        check("almost_full", 32'(almost_full), 32'(occ >= c_depth - 2));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rd_data", 32'(rd_data), (occ != 0) ? 32'(sb_q[0]) : 32'd0);
        rx_valid = rv;
        rx_data  = d;
        rd_en    = rd;
        ovf_clr  = clr;
        pop  = rd && (occ != 0);
        push = rv && ((occ < c_depth) || pop);
        if (pop)  void'(sb_q.pop_front());
        if (push) sb_q.push_back(d);
        if (rv && !push) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic do_reset(input logic rv);
        rst      = 1'b1;
        rx_valid = rv;
        rx_data  = 8'hEE;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        sb_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) cycle(1'b1, base + 8'(i), 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (sb_q.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_ovf       = 1'b0;
        rst         = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        rd_en       = 1'b0;
        ovf_clr     = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b1);
        check("reset_count", 32'(count), 32'd0);

        // Single byte in and out.
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        check("t1_rd_data", 32'(rd_data), 32'h55);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, drain in order, then pop while empty.
        fill(c_depth, 8'h01);
        check("t2_full", 32'(full), 32'd1);
        drain();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Overflow set, clear, and set-beats-clear.
        fill(c_depth, 8'h01);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        check("t3_ovf_set", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_ovf_clr", 32'(overflow), 32'd0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b1);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);
        drain();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous push and pop.
        fill(c_depth, 8'h01);
        cycle(1'b1, 8'h36, 1'b1, 1'b0);
        check("t4_count", 32'(count), 32'(c_depth));
        check("t4_no_ovf", 32'(overflow), 32'd0);
        drain();

        // Wrap-around with occupancy held at 2..3.
        fill(2, 8'h80);
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0:       cycle(1'b1, 8'(8'h82 + i), 1'b0, 1'b0);
                2:       cycle(1'b0, 8'h00, 1'b1, 1'b0);
                default: cycle(1'b1, 8'(8'h82 + i), 1'b1, 1'b0);
            endcase
        end
        drain();

        // Empty with simultaneous push and pop: only the push happens.
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        check("empty_pushpop_count", 32'(count), 32'd1);
        drain();

        // Reset mid-stream discards content and ignores rx_valid.
        fill(2, 8'h55);
        cycle(1'b1, 8'h36, 1'b0, 1'b0);
        do_reset(1'b1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
